// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_loader: UART boot loader. Sends 0x99, receives a little-endian   |
// | size and payload, writes it word by word into instruction memory, then    |
// | acks with 0xAA. Optional size check: PROGRAM_LOADER_SIZE_CHECK_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module program_loader #(
  parameter int IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_rdata,
  input  logic                   rx_rdata_ready,
  input  logic                   rx_ferr,
  output logic [7:0]             tx_sdata,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   load_done,
  output logic                   load_error,
  output logic                   rx_ferr_seen
);

  localparam logic [7:0] c_sync_byte = 8'h99;
  localparam logic [7:0] c_ack_byte  = 8'hAA;

  typedef enum logic [2:0] {
    SEND_SYNC = 3'd0,
    RECV_SIZE = 3'd1,
    RECV_DATA = 3'd2,
    SEND_ACK  = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  state_t                 r_state,       w_state_next;
  logic [1:0]             r_size_lane,   w_size_lane_next;
  logic [31:0]            r_size,        w_size_next;
  logic [31:0]            r_byte_cnt,    w_byte_cnt_next;
  logic [31:0]            r_word,        w_word_next;
  logic [IMEM_ADDR_W-1:0] r_widx,        w_widx_next;
  logic                   r_guard;
  logic                   r_tx_start,    w_tx_start_next;
  logic [7:0]             r_tx_sdata,    w_tx_sdata_next;
  logic                   r_imem_we,     w_imem_we_next;
  logic [IMEM_ADDR_W-1:0] r_imem_addr,   w_imem_addr_next;
  logic [31:0]            r_imem_wdata,  w_imem_wdata_next;
  logic                   r_ferr_seen,   w_ferr_seen_next;

  logic [31:0]            w_size_full;
  logic [31:0]            w_word_merged;
  logic                   w_last_byte;
  logic                   w_size_bad;
  logic                   w_tx_ok;

  // The transmitter may not raise busy until the cycle after tx_start, so
  // busy is not trusted during the start cycle and the one following it.
  assign w_tx_ok     = !tx_busy && !r_guard && !r_tx_start;
  assign w_last_byte = (r_byte_cnt + 32'd1) == r_size;

  always_comb begin
    w_size_full = r_size;
    w_size_full[{r_size_lane, 3'b000} +: 8] = rx_rdata;
  end

  // A fresh word starts from zero so a trailing partial word is zero-padded.
  always_comb begin
    w_word_merged = (r_byte_cnt[1:0] == 2'd0) ? 32'd0 : r_word;
    w_word_merged[{r_byte_cnt[1:0], 3'b000} +: 8] = rx_rdata;
  end

`ifdef PROGRAM_LOADER_SIZE_CHECK_EN
  localparam logic [32:0] c_capacity = 33'd4 << IMEM_ADDR_W;
  assign w_size_bad = ({1'b0, w_size_full} > c_capacity) || (w_size_full[1:0] != 2'b00);
  assign load_error = (r_state == ERROR);
`else
  assign w_size_bad = 1'b0;
  assign load_error = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_size_lane_next  = r_size_lane;
    w_size_next       = r_size;
    w_byte_cnt_next   = r_byte_cnt;
    w_word_next       = r_word;
    w_widx_next       = r_widx;
    w_tx_start_next   = 1'b0;
    w_tx_sdata_next   = r_tx_sdata;
    w_imem_we_next    = 1'b0;
    w_imem_addr_next  = r_imem_addr;
    w_imem_wdata_next = r_imem_wdata;
    w_ferr_seen_next  = r_ferr_seen;

    case (r_state)
      SEND_SYNC: begin
        if (w_tx_ok) begin
          w_tx_start_next = 1'b1;
          w_tx_sdata_next = c_sync_byte;
          w_state_next    = RECV_SIZE;
        end
      end

      RECV_SIZE: begin
        if (rx_rdata_ready) begin
          w_ferr_seen_next = r_ferr_seen | rx_ferr;
          w_size_next      = w_size_full;
          w_size_lane_next = r_size_lane + 2'd1;
          if (r_size_lane == 2'd3) begin
            if (w_size_full == 32'd0) begin
              w_state_next = SEND_ACK;
            end else if (w_size_bad) begin
              w_state_next = ERROR;
            end else begin
              w_state_next = RECV_DATA;
            end
          end
        end
      end

      RECV_DATA: begin
        if (rx_rdata_ready) begin
          w_ferr_seen_next = r_ferr_seen | rx_ferr;
          w_word_next      = w_word_merged;
          w_byte_cnt_next  = r_byte_cnt + 32'd1;
          if (r_byte_cnt[1:0] == 2'd3 || w_last_byte) begin
            w_imem_we_next    = 1'b1;
            w_imem_wdata_next = w_word_merged;
            w_imem_addr_next  = r_widx;
            w_widx_next       = r_widx + IMEM_ADDR_W'(1);
          end
          if (w_last_byte) begin
            w_state_next = SEND_ACK;
          end
        end
      end

      SEND_ACK: begin
        if (w_tx_ok) begin
          w_tx_start_next = 1'b1;
          w_tx_sdata_next = c_ack_byte;
          w_state_next    = DONE;
        end
      end

      DONE, ERROR: begin
      end

      default: w_state_next = SEND_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= SEND_SYNC;
      r_size_lane  <= 2'd0;
      r_size       <= 32'd0;
      r_byte_cnt   <= 32'd0;
      r_word       <= 32'd0;
      r_widx       <= '0;
      r_guard      <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_sdata   <= 8'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_ferr_seen  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_size_lane  <= w_size_lane_next;
      r_size       <= w_size_next;
      r_byte_cnt   <= w_byte_cnt_next;
      r_word       <= w_word_next;
      r_widx       <= w_widx_next;
      r_guard      <= r_tx_start;
      r_tx_start   <= w_tx_start_next;
      r_tx_sdata   <= w_tx_sdata_next;
      r_imem_we    <= w_imem_we_next;
      r_imem_addr  <= w_imem_addr_next;
      r_imem_wdata <= w_imem_wdata_next;
      r_ferr_seen  <= w_ferr_seen_next;
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_sdata     = r_tx_sdata;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign rx_ferr_seen = r_ferr_seen;
  assign load_done    = (r_state == DONE);

endmodule
`default_nettype wire
